// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator buffer-side blocks: default bus
// widths and the write-sequencer state type.
package accel_pkg;

    // Default BRAM address width (16K-word buffers).
    localparam int ADDR_WIDTH_DEF = 14;

    // Default stream / BRAM data width.
    localparam int DATA_WIDTH_DEF = 16;

    // Write sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage : accel_pkg

// File: rtl/bram_write_sequencer_if.sv
// Bundle of the range-configuration handshake, the input data stream and the
// single-port BRAM write port. The producer side (compute engine / bench)
// uses the master modport; the sequencer uses the slave modport.
interface bram_write_sequencer_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
);

    // Range configuration handshake.
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH-1:0] end_addr;

    // Input data stream.
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;

    // BRAM write port.
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    // Status.
    logic                  busy;
    logic                  done;
    logic                  cfg_err;

    // Producer of ranges and data; observer of the write port and status.
    modport master (
        output cfg_valid,
        output start_addr,
        output end_addr,
        output in_valid,
        output in_data,
        input  cfg_ready,
        input  in_ready,
        input  we,
        input  waddr,
        input  wdata,
        input  busy,
        input  done,
        input  cfg_err
    );

    // The sequencer itself.
    modport slave (
        input  cfg_valid,
        input  start_addr,
        input  end_addr,
        input  in_valid,
        input  in_data,
        output cfg_ready,
        output in_ready,
        output we,
        output waddr,
        output wdata,
        output busy,
        output done,
        output cfg_err
    );

endinterface : bram_write_sequencer_if

// File: rtl/dffre.sv
// Enable flop primitive with synchronous active-high reset. Every register in
// the write sequencer is an instance of this cell so reset and enable behaviour
// is uniform across the datapath and control.
module dffre #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when enabled; reset clears to zero and wins over enable.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values,
        // independent of the order in which always blocks are evaluated.
        if (r) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : dffre

// File: rtl/bram_write_sequencer.sv
// BRAM write sequencer: accepts an inclusive address range, then writes one
// stream beat per cycle into consecutive BRAM addresses. The write port is
// registered, so each accepted beat appears on we/waddr/wdata one cycle
// later. The final write coincides with a one-cycle done pulse, after which
// the block returns to IDLE. Ranges with end < start are rejected with a
// one-cycle cfg_err pulse.
module bram_write_sequencer
    import accel_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    bram_write_sequencer_if.slave  bus
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                  rst;

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            state_q;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  addr_en;
    logic [ADDR_WIDTH-1:0] end_q;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  cfg_err_q;

    logic                  cfg_fire;
    logic                  range_ok;
    logic                  cfg_accept;
    logic                  cfg_reject;
    logic                  beat;
    logic                  last_beat;

    logic                  cfg_ready;
    logic                  in_ready;
    logic                  busy;
    logic                  done;

    // The flop primitive resets high; the system reset is active low and is
    // sampled synchronously inside each flop, so a mid-transfer reset simply
    // abandons the range on the next edge.
    assign rst = ~rstn;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // A range is offered only while idle; end == start is a valid 1-word range.
    assign cfg_fire   = (state == ST_IDLE) && bus.cfg_valid;
    assign range_ok   = (bus.end_addr >= bus.start_addr);
    assign cfg_accept = cfg_fire && range_ok;
    assign cfg_reject = cfg_fire && !range_ok;

    // in_ready is a pure decode of WRITE, so a beat is in_valid while in WRITE.
    assign beat      = (state == ST_WRITE) && bus.in_valid;
    assign last_beat = beat && (addr_q == end_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    dffre #(.WIDTH(2)) u_state_reg (
        .clk (clk),
        .r   (rst),
        .en  (1'b1),
        .d   (state_nxt),
        .q   (state_q)
    );

    assign state = state_t'(state_q);

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // Advance IDLE -> WRITE on an accepted range, WRITE -> FINISH on the last
    // beat, and FINISH -> IDLE unconditionally.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cfg_accept) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_beat) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    // Handshake readiness and status flags are decoded from the current state.
    always_comb begin
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
            end
            ST_WRITE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_FINISH: begin
                done = 1'b1;
            end
            default: begin
                cfg_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address counter and end register
    // ------------------------------------------------------------------
    // Load the start address on an accepted range, otherwise step by one per
    // beat. After the last beat it may wrap to zero; that value is never used.
    assign addr_d  = cfg_accept ? bus.start_addr : (addr_q + ADDR_WIDTH'(1));
    assign addr_en = cfg_accept || beat;

    dffre #(.WIDTH(ADDR_WIDTH)) u_addr_reg (
        .clk (clk),
        .r   (rst),
        .en  (addr_en),
        .d   (addr_d),
        .q   (addr_q)
    );

    dffre #(.WIDTH(ADDR_WIDTH)) u_end_reg (
        .clk (clk),
        .r   (rst),
        .en  (cfg_accept),
        .d   (bus.end_addr),
        .q   (end_q)
    );

    // ------------------------------------------------------------------
    // Registered BRAM write port
    // ------------------------------------------------------------------
    // we follows the beat every cycle; address and data only load on a beat
    // so they hold their last values while we is low.
    dffre #(.WIDTH(1)) u_we_reg (
        .clk (clk),
        .r   (rst),
        .en  (1'b1),
        .d   (beat),
        .q   (we_q)
    );

    dffre #(.WIDTH(ADDR_WIDTH)) u_waddr_reg (
        .clk (clk),
        .r   (rst),
        .en  (beat),
        .d   (addr_q),
        .q   (waddr_q)
    );

    dffre #(.WIDTH(DATA_WIDTH)) u_wdata_reg (
        .clk (clk),
        .r   (rst),
        .en  (beat),
        .d   (bus.in_data),
        .q   (wdata_q)
    );

    // One-cycle error pulse for every rejected range presentation.
    dffre #(.WIDTH(1)) u_cfg_err_reg (
        .clk (clk),
        .r   (rst),
        .en  (1'b1),
        .d   (cfg_reject),
        .q   (cfg_err_q)
    );

    // ------------------------------------------------------------------
    // Interface drive
    // ------------------------------------------------------------------
    assign bus.cfg_ready = cfg_ready;
    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;

endmodule : bram_write_sequencer

// File: tb/tb_bram_write_sequencer.sv
// Testbench for bram_write_sequencer. A count-based reference model predicts
// every output each cycle; directed scenarios add hand-computed expectations,
// followed by randomized ranges with a stalling stream and cfg noise.
module tb_bram_write_sequencer;
    import accel_pkg::*;

    localparam int AW       = ADDR_WIDTH_DEF;
    localparam int DW       = DATA_WIDTH_DEF;
    localparam int MAX_ADDR = (1 << AW) - 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    bram_write_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bram_write_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a transfer is "open" while beats remain; the beat
    // that consumes the last remaining count produces the done write.
    // ------------------------------------------------------------------
    bit       armed = 1'b0;
    int       m_left = 0;
    int       m_next = 0;
    bit       e_cfg_ready, e_in_ready, e_busy, e_done, e_cfg_err, e_we;
    int       e_waddr, e_wdata;

    always @(negedge clk) begin
        bit n_we, n_done, n_err;
        if (armed) begin
            check("cfg_ready", bus.cfg_ready, e_cfg_ready);
            check("in_ready",  bus.in_ready,  e_in_ready);
            check("busy",      bus.busy,      e_busy);
            check("done",      bus.done,      e_done);
            check("cfg_err",   bus.cfg_err,   e_cfg_err);
            check("we",        bus.we,        e_we);
            check("waddr",     bus.waddr,     e_waddr);
            check("wdata",     bus.wdata,     e_wdata);
        end
        // Predict outputs after the coming rising edge from the inputs now stable.
        if (!rstn) begin
            m_left      = 0;
            m_next      = 0;
            e_we        = 1'b0;
            e_waddr     = 0;
            e_wdata     = 0;
            e_cfg_err   = 1'b0;
            e_done      = 1'b0;
            e_cfg_ready = 1'b1;
            e_in_ready  = 1'b0;
            e_busy      = 1'b0;
            armed       = 1'b1;
        end else begin
            n_we   = 1'b0;
            n_done = 1'b0;
            n_err  = 1'b0;
            if (e_cfg_ready && bus.cfg_valid) begin
                if (int'(bus.end_addr) >= int'(bus.start_addr)) begin
                    m_next = int'(bus.start_addr);
                    m_left = int'(bus.end_addr) - int'(bus.start_addr) + 1;
                end else begin
                    n_err = 1'b1;
                end
            end else if (e_in_ready && bus.in_valid) begin
                n_we    = 1'b1;
                e_waddr = m_next;
                e_wdata = int'(bus.in_data);
                m_next  = (m_next + 1) % (MAX_ADDR + 1);
                m_left  = m_left - 1;
                n_done  = (m_left == 0);
            end
            e_we        = n_we;
            e_done      = n_done;
            e_cfg_err   = n_err;
            e_in_ready  = (m_left > 0);
            e_busy      = (m_left > 0);
            e_cfg_ready = (m_left == 0) && !n_done;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input int s, input int e);
        bus.cfg_valid  = 1'b1;
        bus.start_addr = AW'(s);
        bus.end_addr   = AW'(e);
        tick();
        bus.cfg_valid  = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pat [7];
        int k, n, last_addr;
        bit got_done;

        bus.cfg_valid  = 1'b0;
        bus.start_addr = '0;
        bus.end_addr   = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;

        // Reset
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        check("rst_cfg_ready", bus.cfg_ready, 1);
        check("rst_we",        bus.we,        0);
        check("rst_waddr",     bus.waddr,     0);
        check("rst_wdata",     bus.wdata,     0);
        check("rst_busy",      bus.busy,      0);
        check("rst_done",      bus.done,      0);
        check("rst_cfg_err",   bus.cfg_err,   0);

        // Basic range 0x10..0x13
        send_cfg('h10, 'h13);
        check("basic_in_ready",  bus.in_ready,  1);
        check("basic_cfg_ready", bus.cfg_ready, 0);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'('hA0 + i);
            tick();
            check("basic_we",    bus.we,    1);
            check("basic_waddr", bus.waddr, 'h10 + i);
            check("basic_wdata", bus.wdata, 'hA0 + i);
            check("basic_done",  bus.done,  (i == 3) ? 1 : 0);
        end
        bus.in_valid = 1'b0;
        check("basic_in_ready_drop", bus.in_ready, 0);
        tick();
        check("basic_cfg_ready_back", bus.cfg_ready, 1);
        check("basic_we_off",         bus.we,        0);
        check("basic_waddr_hold",     bus.waddr,     'h13);

        // Single word with in_valid held high
        send_cfg('h2000, 'h2000);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hBEEF;
        tick();
        check("single_we",       bus.we,       1);
        check("single_waddr",    bus.waddr,    'h2000);
        check("single_wdata",    bus.wdata,    'hBEEF);
        check("single_done",     bus.done,     1);
        check("single_in_ready", bus.in_ready, 0);
        tick();
        check("single_no_extra", bus.we,        0);
        check("single_idle",     bus.cfg_ready, 1);
        bus.in_valid = 1'b0;

        // Stalled stream over 0..3
        pat = '{1, 0, 0, 1, 1, 0, 1};
        send_cfg(0, 3);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = pat[i][0];
            bus.in_data  = DW'($urandom);
            tick();
            if (pat[i] != 0) begin
                check("stall_we",    bus.we,    1);
                check("stall_waddr", bus.waddr, k);
                k++;
            end else begin
                check("stall_we_idle", bus.we, 0);
            end
        end
        check("stall_done", bus.done, 1);
        bus.in_valid = 1'b0;
        tick();

        // Rejected range
        send_cfg('h0100, 'h00FF);
        check("bad_cfg_err",   bus.cfg_err,   1);
        check("bad_cfg_ready", bus.cfg_ready, 1);
        check("bad_busy",      bus.busy,      0);
        check("bad_we",        bus.we,        0);
        tick();
        check("bad_err_pulse", bus.cfg_err, 0);

        // Full range 0..0x3FFF
        send_cfg(0, MAX_ADDR);
        bus.in_valid = 1'b1;
        n         = 0;
        last_addr = -1;
        got_done  = 1'b0;
        for (int c = 0; c < 20000 && !got_done; c++) begin
            bus.in_data = DW'($urandom);
            tick();
            if (bus.we) n++;
            if (bus.done) begin
                got_done  = 1'b1;
                last_addr = int'(bus.waddr);
            end
        end
        check("full_done",  got_done,  1);
        check("full_count", n,         MAX_ADDR + 1);
        check("full_last",  last_addr, MAX_ADDR);
        tick();
        check("full_no_wrap_write", bus.we, 0);
        bus.in_valid = 1'b0;

        // Mid-transfer reset, then a fresh range
        send_cfg('h40, 'h4F);
        bus.in_valid = 1'b1;
        repeat (5) begin
            bus.in_data = DW'($urandom);
            tick();
        end
        check("mid_waddr", bus.waddr, 'h44);
        rstn = 1'b0;
        tick();
        check("mid_rst_we",        bus.we,        0);
        check("mid_rst_busy",      bus.busy,      0);
        check("mid_rst_cfg_ready", bus.cfg_ready, 1);
        check("mid_rst_done",      bus.done,      0);
        rstn         = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        send_cfg('h50, 'h51);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0001;
        tick();
        check("post_rst_waddr0", bus.waddr, 'h50);
        bus.in_data = 16'h0002;
        tick();
        check("post_rst_waddr1", bus.waddr, 'h51);
        check("post_rst_done",   bus.done,  1);
        bus.in_valid = 1'b0;
        tick();

        // Randomized ranges with stalls, cfg noise and occasional bad ranges
        for (int t = 0; t < 40; t++) begin
            int  s, e, len;
            bit  bad_r, seen;
            s     = $urandom_range(0, MAX_ADDR);
            len   = $urandom_range(1, 12);
            bad_r = ($urandom_range(0, 5) == 0) && (s > 0);
            if (bad_r) e = s - 1;
            else       e = (s + len - 1 > MAX_ADDR) ? MAX_ADDR : s + len - 1;
            send_cfg(s, e);
            if (bad_r) begin
                check("rand_cfg_err", bus.cfg_err, 1);
            end else begin
                seen = 1'b0;
                for (int c = 0; c < 400 && !seen; c++) begin
                    bus.in_valid   = $urandom_range(0, 1) == 1;
                    bus.in_data    = DW'($urandom);
                    bus.cfg_valid  = $urandom_range(0, 1) == 1;
                    bus.start_addr = AW'($urandom);
                    bus.end_addr   = AW'($urandom);
                    tick();
                    if (bus.done) seen = 1'b1;
                end
                bus.cfg_valid = 1'b0;
                bus.in_valid  = 1'b0;
                check("rand_done", seen, 1);
                tick();
            end
        end

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bram_write_sequencer
